write_mem_sink: RTL and testbench

WRITE_MEM_SINK -- requirements
Module: write_mem_sink

---
 rtl/wms_pkg.sv | 21 ++
 rtl/write_mem_sink_if.sv | 29 ++
 rtl/wms_fifo.sv | 56 +++++
 rtl/write_mem_sink.sv | 133 +++++++++++++
 tb/tb_write_mem_sink.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wms_pkg.sv
// Shared definitions for write_mem_sink: parameter defaults, drain FSM states
// and a width helper. Used with and without the WMS_RANGE_CHECK_EN build macro.
package wms_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MEM_DEPTH  = 16;
  localparam int DEF_WR_LAT     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } drain_state_e;

  // Bits needed to hold the values 0 .. n-1, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/write_mem_sink_if.sv
// Word handshake between a WriteSlave (master side) and write_mem_sink (slave side).
// Signal names follow the WriteSlave port naming.
interface write_mem_sink_if
  import wms_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [DATA_W-1:0] Datain;
  logic [ADDR_W-1:0] addressin;
  logic              writeavail;
  logic              finishwrite;

  modport master (
    output Datain,
    output addressin,
    output writeavail,
    input  finishwrite
  );

  modport slave (
    input  Datain,
    input  addressin,
    input  writeavail,
    output finishwrite
  );

endinterface

// File: rtl/wms_fifo.sv
// Ingress FIFO for write_mem_sink: power-of-two depth, extra pointer bit to tell
// full from empty, combinational head read, synchronous active-high reset.
module wms_fifo
  import wms_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = width_of(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] store [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage arrays carry no reset; the pointers alone define validity,
  // and leaving the array unreset lets it map onto RAM/LUT-RAM.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout = store[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/write_mem_sink.sv
// Buffered write sink: words from a WriteSlave queue in wms_fifo, a two-state drain
// FSM commits each one WR_LAT cycles after pop. Optional macro: WMS_RANGE_CHECK_EN.
module write_mem_sink
  import wms_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int WR_LAT     = DEF_WR_LAT
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  write_mem_sink_if.slave              wr,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic [7:0]                   wr_count,
  output logic [7:0]                   err_count,
  output logic                         busy
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int LAT_W = width_of(WR_LAT);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(WR_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_din;
  entry_t            fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  drain_state_e      state;
  logic [LAT_W-1:0]  lat_cnt;
  entry_t            work;
  logic [7:0]        wr_cnt_q;
  logic              commit;
  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Ready comes from FIFO pointer state only and is held low during reset.
  assign wr.finishwrite = ~ARESET & ~fifo_full;
  assign fifo_push      = wr.writeavail & wr.finishwrite;
  assign fifo_din       = '{addr: wr.addressin, data: wr.Datain};
  assign fifo_pop       = (state == IDLE) & ~fifo_empty & ~ARESET;

  wms_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign commit = (state == WAIT) && (lat_cnt == '0);

`ifdef WMS_RANGE_CHECK_EN
  assign in_range = (work.addr >> 2) < ADDR_W'(MEM_DEPTH);
`else
  assign in_range = 1'b1;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      wr_cnt_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            work    <= fifo_dout;
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_ONE;
          end else begin
            state <= IDLE;
            if (in_range) wr_cnt_q <= wr_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

`ifdef WMS_RANGE_CHECK_EN
  logic [7:0] err_cnt_q;

  // Dropped-word counter saturates so a flood of bad addresses stays visible.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_cnt_q <= '0;
    end else if (commit && !in_range && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  // Byte offset bits (and, without range checking, the upper bits) carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^work.addr;

  assign mem_we = commit & in_range & ~ARESET;

  always_ff @(posedge ACLK) begin
    if (mem_we) mem[work.addr[IDX_W+1:2]] <= work.data;
  end

  assign rd_data  = mem[rd_addr];
  assign wr_count = wr_cnt_q;
  assign busy     = ~fifo_empty | (state == WAIT);

endmodule

// File: tb/tb_write_mem_sink.sv
// Randomized self-checking bench for write_mem_sink against an in-order commit model.
// Build with or without WMS_RANGE_CHECK_EN; expectations follow the macro.
module tb_write_mem_sink;
  import wms_pkg::*;

  localparam int DATA_W     = DEF_DATA_W;
  localparam int ADDR_W     = DEF_ADDR_W;
  localparam int FIFO_DEPTH = DEF_FIFO_DEPTH;
  localparam int MEM_DEPTH  = DEF_MEM_DEPTH;
  localparam int WR_LAT     = DEF_WR_LAT;
  localparam int IDX_W      = $clog2(MEM_DEPTH);

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        wr_count;
  logic [7:0]        err_count;
  logic              busy;

  write_mem_sink_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr_if ();

  write_mem_sink #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .WR_LAT     (WR_LAT)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .wr        (wr_if),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_count  (wr_count),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: every accepted word commits, in acceptance order.
  logic [DATA_W-1:0] mem_exp [MEM_DEPTH];
  bit                mem_known [MEM_DEPTH];
  int                exp_wr;
  int                exp_err;

  function automatic bit addr_ok(input logic [ADDR_W-1:0] a);
`ifdef WMS_RANGE_CHECK_EN
    return (a >> 2) < MEM_DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_commit(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int idx;
    idx = int'((a >> 2) % MEM_DEPTH);
    if (addr_ok(a)) begin
      mem_exp[idx]   = d;
      mem_known[idx] = 1'b1;
      exp_wr         = (exp_wr + 1) % 256;
    end else if (exp_err < 255) begin
      exp_err = exp_err + 1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input bit track);
    bit fw;
    bit done;
    done = 1'b0;
    wr_if.addressin  = a;
    wr_if.Datain     = d;
    wr_if.writeavail = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge ACLK);
      fw = wr_if.finishwrite;
      @(posedge ACLK);
      if (fw) done = 1'b1;
    end
    #1;
    wr_if.writeavail = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL push_accept: addr %0h not accepted within 64 cycles, required acceptance", a);
    end else if (track) begin
      model_commit(a, d);
    end
  endtask

  task automatic wait_drain();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 400 && !idle; c++) begin
      @(negedge ACLK);
      if (!busy) idle = 1'b1;
    end
    n_checks++;
    if (!idle) begin
      n_fail++;
      $display("FAIL drain_timeout: busy=%0b after 400 cycles, required 0", busy);
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic verify_state(input string tag);
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (mem_known[i]) begin
        rd_addr = IDX_W'(i);
        #1;
        n_checks++;
        if (rd_data !== mem_exp[i]) begin
          n_fail++;
          $display("FAIL %s mem[%0d]: got %0h required %0h", tag, i, rd_data, mem_exp[i]);
        end
      end
    end
    n_checks++;
    if (wr_count !== 8'(exp_wr)) begin
      n_fail++;
      $display("FAIL %s wr_count: got %0d required %0d", tag, wr_count, exp_wr);
    end
    n_checks++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d required %0d", tag, err_count, exp_err);
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    n_checks++;
    if (wr_if.finishwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_low: finishwrite=%0b required 0", wr_if.finishwrite);
    end
    @(posedge ACLK);
    #1;
    ARESET  = 1'b0;
    exp_wr  = 0;
    exp_err = 0;
    @(negedge ACLK);
    n_checks++;
    if (wr_if.finishwrite !== 1'b1 || busy !== 1'b0 || wr_count !== 8'd0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_release: fw=%0b busy=%0b wr=%0d err=%0d required 1 0 0 0",
               wr_if.finishwrite, busy, wr_count, err_count);
    end
    @(posedge ACLK);
    #1;
  endtask

  // Offering a word throughout reset must not leave anything queued.
  task automatic test_reset();
    ARESET           = 1'b1;
    wr_if.addressin  = 32'h4;
    wr_if.Datain     = 32'hDEAD_BEEF;
    wr_if.writeavail = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    n_checks++;
    if (wr_if.finishwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_ready: finishwrite=%0b required 0", wr_if.finishwrite);
    end
    @(posedge ACLK);
    #1;
    ARESET           = 1'b0;
    wr_if.writeavail = 1'b0;
    exp_wr           = 0;
    exp_err          = 0;
    repeat (WR_LAT + 3) @(posedge ACLK);
    @(negedge ACLK);
    n_checks++;
    if (wr_if.finishwrite !== 1'b1 || busy !== 1'b0 || wr_count !== 8'd0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: fw=%0b busy=%0b wr=%0d err=%0d required 1 0 0 0",
               wr_if.finishwrite, busy, wr_count, err_count);
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_preload();
    for (int i = 0; i < MEM_DEPTH; i++) begin
      push_word(ADDR_W'(4 * i), DATA_W'($urandom), 1'b1);
    end
    wait_drain();
    verify_state("preload");
  endtask

  // One word into an empty sink: commit lands WR_LAT+1 edges after the push edge.
  task automatic test_single();
    logic [DATA_W-1:0] old_val;
    logic [7:0]        wr_before;
    old_val   = mem_exp[2];
    wr_before = 8'(exp_wr);
    rd_addr   = IDX_W'(2);
    push_word(32'h8, 32'h1, 1'b1);
    for (int k = 0; k <= WR_LAT; k++) begin
      @(negedge ACLK);
      n_checks++;
      if (wr_count !== wr_before || rd_data !== old_val) begin
        n_fail++;
        $display("FAIL single_early k=%0d: wr=%0d data=%0h required %0d %0h",
                 k, wr_count, rd_data, wr_before, old_val);
      end
    end
    @(negedge ACLK);
    n_checks++;
    if (wr_count !== wr_before + 8'd1 || rd_data !== 32'h1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_commit: wr=%0d data=%0h busy=%0b required %0d 1 0",
               wr_count, rd_data, busy, wr_before + 8'd1);
    end
    @(posedge ACLK);
    #1;
    verify_state("single");
  endtask

  // writeavail held high; the sink throttles and every word still lands.
  task automatic test_burst();
    int  accepted;
    int  outstanding;
    bit  fw;
    bit  saw_full;
    accepted = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 200 && accepted < 8; c++) begin
      wr_if.addressin  = ADDR_W'(4 * accepted);
      wr_if.Datain     = DATA_W'(accepted + 1);
      wr_if.writeavail = 1'b1;
      @(negedge ACLK);
      fw          = wr_if.finishwrite;
      outstanding = accepted - int'(wr_count);
      n_checks++;
      if (!fw) begin
        saw_full = 1'b1;
        if (outstanding < FIFO_DEPTH) begin
          n_fail++;
          $display("FAIL burst_early_stall: outstanding=%0d while ready low, required >=%0d",
                   outstanding, FIFO_DEPTH);
        end
      end else if (outstanding > FIFO_DEPTH) begin
        n_fail++;
        $display("FAIL burst_overfill: outstanding=%0d while ready high, required <=%0d",
                 outstanding, FIFO_DEPTH);
      end
      @(posedge ACLK);
      if (fw) begin
        model_commit(ADDR_W'(4 * accepted), DATA_W'(accepted + 1));
        accepted++;
      end
      #1;
    end
    wr_if.writeavail = 1'b0;
    n_checks++;
    if (!saw_full || accepted != 8) begin
      n_fail++;
      $display("FAIL burst_flow: saw_full=%0b accepted=%0d required 1 8", saw_full, accepted);
    end
    wait_drain();
    n_checks++;
    if (wr_count !== 8'd8) begin
      n_fail++;
      $display("FAIL burst_count: wr_count=%0d required 8", wr_count);
    end
    verify_state("burst");
  endtask

  task automatic test_range();
    push_word(32'h40, DATA_W'($urandom), 1'b1);
    wait_drain();
`ifdef WMS_RANGE_CHECK_EN
    n_checks++;
    if (err_count !== 8'd1 || wr_count !== 8'd0) begin
      n_fail++;
      $display("FAIL range_drop: err=%0d wr=%0d required 1 0", err_count, wr_count);
    end
`else
    n_checks++;
    if (err_count !== 8'd0 || wr_count !== 8'd1) begin
      n_fail++;
      $display("FAIL range_wrap: err=%0d wr=%0d required 0 1", err_count, wr_count);
    end
`endif
    verify_state("range");
  endtask

  // Reset lands on the edge that would have committed the first of three words.
  task automatic test_reset_midflight();
    push_word(32'h14, 32'hAAAA_0001, 1'b0);
    push_word(32'h18, 32'hAAAA_0002, 1'b0);
    push_word(32'h1C, 32'hAAAA_0003, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_busy: busy=%0b required 1", busy);
    end
    do_reset();
    repeat (2 * WR_LAT + 6) @(posedge ACLK);
    @(negedge ACLK);
    n_checks++;
    if (wr_count !== 8'd0 || busy !== 1'b0 || wr_if.finishwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_abandon: wr=%0d busy=%0b fw=%0b required 0 0 1",
               wr_count, busy, wr_if.finishwrite);
    end
    @(posedge ACLK);
    #1;
    verify_state("midflight");
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 120; i++) begin
`ifdef WMS_RANGE_CHECK_EN
      a = ADDR_W'($urandom_range(0, 8 * MEM_DEPTH - 1));
`else
      a = ADDR_W'($urandom);
`endif
      push_word(a, DATA_W'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge ACLK);
        #1;
      end
    end
    wait_drain();
    verify_state("random");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      push_word(ADDR_W'(4 * $urandom_range(0, MEM_DEPTH - 1)), DATA_W'($urandom), 1'b1);
    end
    wait_drain();
    n_checks++;
    if (wr_count !== 8'd44) begin
      n_fail++;
      $display("FAIL wr_wrap: wr_count=%0d required 44", wr_count);
    end
`ifdef WMS_RANGE_CHECK_EN
    for (int i = 0; i < 260; i++) begin
      push_word(ADDR_W'(32'h40 + 4 * $urandom_range(0, 100)), DATA_W'($urandom), 1'b1);
    end
    wait_drain();
    n_checks++;
    if (err_count !== 8'd255 || wr_count !== 8'd44) begin
      n_fail++;
      $display("FAIL err_saturate: err=%0d wr=%0d required 255 44", err_count, wr_count);
    end
`endif
    verify_state("wrap");
  endtask

  initial begin
    wr_if.writeavail = 1'b0;
    wr_if.addressin  = '0;
    wr_if.Datain     = '0;
    rd_addr          = '0;
    exp_wr           = 0;
    exp_err          = 0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem_exp[i]   = '0;
      mem_known[i] = 1'b0;
    end

    test_reset();
    test_preload();
    do_reset();
    test_single();
    do_reset();
    test_burst();
    do_reset();
    test_range();
    test_reset_midflight();
    test_random();
    test_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
